// File: rtl/mod_counter_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mod_counter_bank
// Function : NCH independent up/down modulo counters sharing one terminal count
//            MAX. Each channel has a synchronous load, a wrap pulse and a sticky
//            load-error flag.
// Revision : 1.0
//------------------------------------------------------------------------------
module mod_counter_bank #(
  parameter int W   = 10,
  parameter int NCH = 4,
  parameter int MAX = 2**(W-1)-1,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   up,
  input  logic [NCH-1:0]   load,
  input  logic [NCH*W-1:0] load_val,
  input  logic             err_clr,
  output logic [NCH*W-1:0] count,
  output logic [NCH-1:0]   wrap,
  output logic [NCH-1:0]   load_err
);

  localparam logic [W-1:0] C_MAX = W'(MAX);
  localparam logic [W-1:0] C_ONE = W'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_ld_val;
    logic         r_wrap;
    logic         w_wrap_nxt;
    logic         r_err;
    logic         w_bad_load;

    assign w_ld_val   = load_val[i*W +: W];
    assign w_bad_load = load[i] && (w_ld_val > C_MAX);

    // Terminal tests use equality so MAX == 2**W-1 never needs a carry bit.
    always_comb begin
      w_cnt_nxt  = r_cnt;
      w_wrap_nxt = 1'b0;
      if (load[i]) begin
        if (!w_bad_load) w_cnt_nxt = w_ld_val;
      end else if (en[i]) begin
        if (up[i]) begin
          if (r_cnt == C_MAX) begin
            w_cnt_nxt  = (SAT != 0) ? C_MAX : '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt + C_ONE;
          end
        end else begin
          if (r_cnt == '0) begin
            w_cnt_nxt  = (SAT != 0) ? '0 : C_MAX;
            w_wrap_nxt = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt - C_ONE;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_wrap <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_wrap <= w_wrap_nxt;
        // A bad load on the same edge as err_clr leaves the flag set.
        if (w_bad_load)   r_err <= 1'b1;
        else if (err_clr) r_err <= 1'b0;
      end
    end

    assign count[i*W +: W] = r_cnt;
    assign wrap[i]         = r_wrap;
    assign load_err[i]     = r_err;

`ifdef FORMAL
    logic r_first = 1'b1;

    always @(posedge clk) r_first <= 1'b0;

    always @(*) assume (!rst_n == r_first);

    always @(posedge clk) begin
      if (rst_n) begin
        assert (r_cnt <= C_MAX);
        if (r_wrap) assert ((r_cnt == '0) || (r_cnt == C_MAX));
        if (!r_first && $past(rst_n) && $past(r_err) && !$past(err_clr))
          assert (r_err);
      end
    end

    always @(posedge clk) begin
      if (rst_n) begin
        cover (r_cnt == C_MAX);
        cover (r_wrap && $past(up[i]) && $past(r_cnt == C_MAX));
        cover (r_wrap && !$past(up[i]) && $past(r_cnt == '0));
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mod_counter_bank
// Function : Directed scoreboard bench for mod_counter_bank, wrap and saturate.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_mod_counter_bank;

  localparam int W   = 4;
  localparam int NCH = 4;
  localparam int MAX = 9;

  typedef struct {
    string      tag;
    int         dut;
    int         ch;
    logic [3:0] cnt;
    logic       wrap;
    logic       err;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   en, up, load;
  logic [NCH-1:0]   en_b, up_b, load_b;
  logic [NCH*W-1:0] load_val;
  logic             err_clr;
  logic [NCH*W-1:0] count_a, count_b;
  logic [NCH-1:0]   wrap_a, wrap_b, err_a, err_b;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mod_counter_bank #(.W(W), .NCH(NCH), .MAX(MAX), .SAT(0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .err_clr(err_clr),
    .count(count_a), .wrap(wrap_a), .load_err(err_a)
  );

  mod_counter_bank #(.W(W), .NCH(NCH), .MAX(MAX), .SAT(1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en_b), .up(up_b), .load(load_b),
    .load_val(load_val), .err_clr(err_clr),
    .count(count_b), .wrap(wrap_b), .load_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic logic [5:0] observe(input int dut, input int ch);
    if (dut == 0) return {count_a[ch*W +: W], wrap_a[ch], err_a[ch]};
    return {count_b[ch*W +: W], wrap_b[ch], err_b[ch]};
  endfunction

  task automatic push(input string tag, input int dut, input int ch,
                      input int cnt, input logic w, input logic e);
    exp_t x;
    x.tag  = tag;
    x.dut  = dut;
    x.ch   = ch;
    x.cnt  = 4'(cnt);
    x.wrap = w;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t       x;
    logic [5:0] o, e;
    while (sb.size() != 0) begin
      x = sb.pop_front();
      o = observe(x.dut, x.ch);
      e = {x.cnt, x.wrap, x.err};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed cnt=%0d wrap=%0b err=%0b, expected cnt=%0d wrap=%0b err=%0b",
               x.tag, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = '0;
    up       = '0;
    load     = '0;
    en_b     = '0;
    up_b     = '0;
    load_b   = '0;
    load_val = '0;
    err_clr  = 1'b0;

    // Reset state on both instances.
    #22;
    for (int c = 0; c < NCH; c++) begin
      push("reset_wrap", 0, c, 0, 1'b0, 1'b0);
      push("reset_sat",  1, c, 0, 1'b0, 1'b0);
    end
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // ch0 counts up through the terminal value and wraps to 0.
    en[0] = 1'b1;
    up[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      push($sformatf("ch0_up_%0d", k), 0, 0, (k == 10) ? 0 : k, k == 10, 1'b0);
      tick();
    end
    en[0] = 1'b0;
    push("ch0_hold", 0, 0, 0, 1'b0, 1'b0);
    tick();

    // ch1 decrement from 0: wrap to MAX vs. saturate at 0.
    en[1]   = 1'b1;
    up[1]   = 1'b0;
    en_b[1] = 1'b1;
    up_b[1] = 1'b0;
    push("ch1_down_wrap", 0, 1, MAX, 1'b1, 1'b0);
    push("ch1_down_sat1", 1, 1, 0, 1'b1, 1'b0);
    tick();
    push("ch1_down_after", 0, 1, MAX - 1, 1'b0, 1'b0);
    push("ch1_down_sat2", 1, 1, 0, 1'b1, 1'b0);
    tick();
    en[1] = 1'b0;
    push("ch1_hold", 0, 1, MAX - 1, 1'b0, 1'b0);
    push("ch1_down_sat3", 1, 1, 0, 1'b1, 1'b0);
    tick();
    en_b[1] = 1'b0;
    push("ch1_sat_idle", 1, 1, 0, 1'b0, 1'b0);
    tick();

    // ch2 load beats enable; an out-of-range load is rejected and flagged.
    load[2]           = 1'b1;
    en[2]             = 1'b1;
    up[2]             = 1'b1;
    load_val[2*W +: W] = 4'd7;
    push("ch2_load_wins", 0, 2, 7, 1'b0, 1'b0);
    tick();
    load_val[2*W +: W] = 4'd12;
    push("ch2_bad_load", 0, 2, 7, 1'b0, 1'b1);
    tick();

    // Bad load and err_clr together keep the flag; err_clr alone clears it.
    err_clr = 1'b1;
    push("ch2_err_set_wins", 0, 2, 7, 1'b0, 1'b1);
    tick();
    load[2] = 1'b0;
    en[2]   = 1'b0;
    push("ch2_err_clr", 0, 2, 7, 1'b0, 1'b0);
    tick();
    err_clr = 1'b0;

    // Loading exactly MAX is legal, then counting up wraps.
    load[2]           = 1'b1;
    load_val[2*W +: W] = 4'd9;
    push("ch2_load_max", 0, 2, MAX, 1'b0, 1'b0);
    tick();
    load[2] = 1'b0;
    en[2]   = 1'b1;
    push("ch2_max_wrap", 0, 2, 0, 1'b1, 1'b0);
    tick();
    en[2] = 1'b0;
    push("ch2_idle", 0, 2, 0, 1'b0, 1'b0);
    push("ch0_indep", 0, 0, 0, 1'b0, 1'b0);
    tick();

    // ch3 counts to 5, then reset drops between clock edges.
    en[3] = 1'b1;
    up[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("ch3_up_%0d", k), 0, 3, k, 1'b0, 1'b0);
      tick();
    end
    en[3] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) push($sformatf("async_rst_ch%0d", c), 0, c, 0, 1'b0, 1'b0);
    drain();
    #2;
    rst_n = 1'b1;
    push("ch3_after_rst", 0, 3, 0, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
